// File: rtl/enoc_injection_arbiter_if.sv
// Handshake bundle between the local requesters, the injection arbiter and the
// network input port (requester valid/enable, network data/valid/ready).
interface enoc_injection_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 64
);
  logic [N_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [N_REQ-1:0]            i_req_val;
  logic [N_REQ-1:0]            o_req_en;
  logic [DATA_WIDTH-1:0]       o_data;
  logic                        o_data_val;
  logic                        i_net_en;

  modport master (
    input  i_req_data,
    input  i_req_val,
    input  i_net_en,
    output o_req_en,
    output o_data,
    output o_data_val
  );

  modport slave (
    output i_req_data,
    output i_req_val,
    output i_net_en,
    input  o_req_en,
    input  o_data,
    input  o_data_val
  );
endinterface

// File: rtl/enoc_injection_arbiter.sv
// Round-robin injection arbiter: N_REQ local sources share one single-entry slot
// feeding the ENoC input port. Define ENOC_ARB_STATS_EN for grant/stall counters.
module enoc_injection_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic clk,
  input  logic reset_n,
`ifdef ENOC_ARB_STATS_EN
  output logic [N_REQ*CNT_WIDTH-1:0] o_grant_cnt,
  output logic [CNT_WIDTH-1:0]       o_stall_cnt,
`endif
  enoc_injection_arbiter_if.master bus
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  slot_state_t           state_r;
  slot_state_t           state_nxt_s;
  logic [PTR_W-1:0]      ptr_r;
  logic [PTR_W-1:0]      ptr_nxt_s;
  logic [DATA_WIDTH-1:0] data_r;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic [PTR_W-1:0]      winner_s;
  logic                  found_s;
  logic                  can_load_s;
  logic                  accept_s;
  logic [N_REQ-1:0]      req_en_s;
  int                    idx_s;

  // Rotating priority search starting at the round-robin pointer
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    idx_s    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = (int'(ptr_r) + k) % N_REQ;
      if (!found_s && bus.i_req_val[idx_s]) begin
        found_s  = 1'b1;
        winner_s = PTR_W'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Accept decision, one-hot enable and next-state logic
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    req_en_s    = '0;
    can_load_s  = (state_r == SLOT_EMPTY) || bus.i_net_en;
    // Gating with reset_n keeps o_req_en silent while the block is held in reset.
    accept_s    = found_s && can_load_s && reset_n;
    sel_data_s  = bus.i_req_data[int'(winner_s)*DATA_WIDTH +: DATA_WIDTH];
    for (int i = 0; i < N_REQ; i++) begin
      req_en_s[i] = accept_s && (winner_s == PTR_W'(i));
    end
    if (accept_s) begin
      ptr_nxt_s = (winner_s == PTR_W'(N_REQ - 1)) ? '0 : winner_s + PTR_W'(1);
    end else begin
      ptr_nxt_s = ptr_r;
    end
    case (state_r)
      SLOT_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = SLOT_FULL;
        end else begin
          state_nxt_s = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        if (accept_s) begin
          state_nxt_s = SLOT_FULL;
        end else if (bus.i_net_en) begin
          state_nxt_s = SLOT_EMPTY;
        end else begin
          state_nxt_s = SLOT_FULL;
        end
      end
      default: state_nxt_s = SLOT_EMPTY;
    endcase
  end

  // Slot state, packet register and round-robin pointer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= SLOT_EMPTY;
      ptr_r   <= '0;
      data_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      if (accept_s) begin
        data_r <= sel_data_s;
      end
    end
  end

  assign bus.o_req_en   = req_en_s;
  assign bus.o_data     = data_r;
  assign bus.o_data_val = (state_r == SLOT_FULL);

`ifdef ENOC_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] grant_cnt_r [N_REQ];
  logic [CNT_WIDTH-1:0] stall_cnt_r;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Saturating per-requester accept counters and stall-cycle counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        grant_cnt_r[i] <= '0;
      end
      stall_cnt_r <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_en_s[i]) begin
          grant_cnt_r[i] <= sat_inc(grant_cnt_r[i]);
        end
      end
      if ((state_r == SLOT_FULL) && !bus.i_net_en) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_grant_out
    assign o_grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] = grant_cnt_r[g];
  end
  assign o_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_enoc_injection_arbiter.sv
// Directed self-checking bench for enoc_injection_arbiter (N_REQ=4, 64-bit packets);
// the statistics section is compiled only with ENOC_ARB_STATS_EN.
module tb_enoc_injection_arbiter;
  localparam int N_REQ      = 4;
  localparam int DATA_WIDTH = 64;
  localparam int CNT_WIDTH  = 4;

  logic clk;
  logic reset_n;
  int   pass_cnt;
  int   total_cnt;

  enoc_injection_arbiter_if #(.N_REQ(N_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

`ifdef ENOC_ARB_STATS_EN
  logic [N_REQ*CNT_WIDTH-1:0] grant_cnt;
  logic [CNT_WIDTH-1:0]       stall_cnt;
`endif

  enoc_injection_arbiter #(
    .N_REQ(N_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef ENOC_ARB_STATS_EN
    .o_grant_cnt(grant_cnt),
    .o_stall_cnt(stall_cnt),
`endif
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset_n   = 1'b0;
    bus.i_net_en  = 1'b1;
    bus.i_req_val = 4'b1111;
    for (int i = 0; i < N_REQ; i++) begin
      bus.i_req_data[i*DATA_WIDTH +: DATA_WIDTH] = 64'hA0 + 64'(i);
    end

    // 1: reset with every requester valid
    tick();
    tick();
    check_eq("rst_req_en", 64'(bus.o_req_en), 64'h0);
    check_eq("rst_val", 64'(bus.o_data_val), 64'h0);
    check_eq("rst_data", bus.o_data, 64'h0);
    reset_n = 1'b1;
    #1;
    check_eq("first_grant", 64'(bus.o_req_en), 64'b0001);

    // 2: round robin with all valid, no stalls
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("rr_data", bus.o_data, 64'hA0 + 64'(k % 4));
      check_eq("rr_val", 64'(bus.o_data_val), 64'h1);
      check_eq("rr_req_en", 64'(bus.o_req_en), 64'h1 << ((k + 1) % 4));
    end

    // 3: single requester 2, then all valid resumes at 3 then 0
    bus.i_req_val = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("solo_req_en", 64'(bus.o_req_en), 64'b0100);
      tick();
      check_eq("solo_data", bus.o_data, 64'hA2);
    end
    bus.i_req_val = 4'b1111;
    #1;
    check_eq("resume_req_en3", 64'(bus.o_req_en), 64'b1000);
    tick();
    check_eq("resume_data3", bus.o_data, 64'hA3);
    check_eq("resume_req_en0", 64'(bus.o_req_en), 64'b0001);
    tick();
    check_eq("resume_data0", bus.o_data, 64'hA0);

    // 4: stall with A1 in the slot, then drain plus accept of requester 2
    tick();
    check_eq("pre_stall_data", bus.o_data, 64'hA1);
    bus.i_net_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("stall_req_en", 64'(bus.o_req_en), 64'h0);
      tick();
      check_eq("stall_data", bus.o_data, 64'hA1);
      check_eq("stall_val", 64'(bus.o_data_val), 64'h1);
    end
    bus.i_net_en = 1'b1;
    #1;
    check_eq("unstall_req_en", 64'(bus.o_req_en), 64'b0100);
    tick();
    check_eq("unstall_data", bus.o_data, 64'hA2);

    // 5: reset while the slot holds A3
    tick();
    check_eq("pre_rst_data", bus.o_data, 64'hA3);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_req_en", 64'(bus.o_req_en), 64'h0);
    tick();
    check_eq("midrst_val", 64'(bus.o_data_val), 64'h0);
    check_eq("midrst_data", bus.o_data, 64'h0);
    reset_n = 1'b1;
    #1;
    check_eq("post_rst_ptr", 64'(bus.o_req_en), 64'b0001);

    // Drain with no accept empties the slot; idle cycles leave the pointer alone
    tick();
    check_eq("acc0_data", bus.o_data, 64'hA0);
    bus.i_req_val = 4'b0000;
    tick();
    check_eq("drain_empty_val", 64'(bus.o_data_val), 64'h0);
    tick();
    check_eq("idle_val", 64'(bus.o_data_val), 64'h0);
    bus.i_req_val = 4'b1111;
    #1;
    check_eq("idle_ptr_kept", 64'(bus.o_req_en), 64'b0010);

`ifdef ENOC_ARB_STATS_EN
    // 6: counter saturation with a 4-bit counter width
    reset_n = 1'b0;
    bus.i_req_val = 4'b0000;
    tick();
    reset_n = 1'b1;
    check_eq("cnt_rst_grant", 64'(grant_cnt), 64'h0);
    check_eq("cnt_rst_stall", 64'(stall_cnt), 64'h0);
    bus.i_req_val = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      tick();
    end
    bus.i_net_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
    end
    check_eq("cnt_grant1", 64'(grant_cnt[1*CNT_WIDTH +: CNT_WIDTH]), 64'd15);
    check_eq("cnt_grant0", 64'(grant_cnt[0*CNT_WIDTH +: CNT_WIDTH]), 64'd0);
    check_eq("cnt_grant2", 64'(grant_cnt[2*CNT_WIDTH +: CNT_WIDTH]), 64'd0);
    check_eq("cnt_grant3", 64'(grant_cnt[3*CNT_WIDTH +: CNT_WIDTH]), 64'd0);
    check_eq("cnt_stall", 64'(stall_cnt), 64'd3);
    bus.i_net_en = 1'b1;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/enoc_injection_arbiter.md
Name: enoc_injection_arbiter

Overview:
Round-robin injection scheduler that shares one ENoC network input port between N_REQ local traffic sources at a node. Each source offers a packet with a valid/enable handshake. The arbiter picks one packet per cycle into a single-entry output slot. The slot drives the network's i_data/i_data_val and is drained under the network's o_en backpressure.

Parameters:
N_REQ, 4, number of local requesters (2..16)
DATA_WIDTH, 64, packet width in bits (matches packet_t)
CNT_WIDTH, 16, width of statistics counters (optional feature only)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
i_req_data  input  N_REQ*DATA_WIDTH  packet from requester i in slice i
i_req_val  input  N_REQ  requester i has a valid packet
o_req_en  output  N_REQ  one-hot accept; requester i's packet is taken this cycle when high
o_data  output  DATA_WIDTH  packet to network i_data
o_data_val  output  1  o_data valid, to network i_data_val
i_net_en  input  1  network ready, from network o_en

Behaviour:
- Reset (reset_n low at clk edge): slot EMPTY, o_data_val=0, o_data=0, rr pointer=0 (requester 0 highest priority). The reset values of o_data_val and o_data are seen after that edge; o_req_en is all zero while reset_n is low.
- Slot FSM, two states:
  - EMPTY: o_data_val=0.
  - FULL: o_data_val=1 and o_data holds the latched packet.
- Drain: occurs when FULL and i_net_en=1 at the edge.
- can_load = EMPTY or drain this cycle (combinational from i_net_en).
- Winner is the first i with i_req_val[i]=1, searching from the rr pointer upward with modulo N_REQ wrap.
- o_req_en[winner]=1 only when can_load=1. o_req_en is at most one-hot and combinational from i_req_val, i_net_en and state.
- On accept: slot loads i_req_data[winner], state becomes FULL, and pointer = (winner+1) mod N_REQ.
- Drain with no accept: state becomes EMPTY. o_data keeps its last value but is don't-care.
- Simultaneous drain and accept: slot stays FULL with the new packet. This gives back-to-back throughput of 1 packet/cycle.
- Stall (FULL, i_net_en=0): o_data and o_data_val are held stable, all o_req_en=0, pointer unchanged.
- No requests: pointer unchanged.
- Latency: packet accepted at edge t is presented on o_data with o_data_val=1 from t until the drain edge.
- Fairness: with all requesters continuously valid and no stalls, grants go 0,1,2,3,0,... No requester waits more than N_REQ-1 accepts.
- Requesters must hold i_req_data/i_req_val stable until o_req_en. The arbiter does not buffer unaccepted requests.
- Reset mid-operation: the slot packet is discarded and no o_req_en is asserted during reset.

Optional Feature:
ENOC_ARB_STATS_EN
- Defined:
  - Adds output o_grant_cnt (N_REQ*CNT_WIDTH), one saturating per-requester accept counter in slice i.
  - Adds output o_stall_cnt (CNT_WIDTH), which counts cycles with FULL and i_net_en=0 and saturates at all-ones.
  - All counters clear to 0 on reset.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
1. Reset with all i_req_val=1 -> o_req_en=0000, o_data_val=0 during reset; first accept after release is requester 0.
2. i_req_val=1111 held, i_net_en=1, req i data=0xA0+i -> o_data sequence A0,A1,A2,A3,A0 on consecutive cycles, o_data_val continuously 1.
3. i_req_val=0100 only -> o_req_en=0100 every cycle, o_data=A2 each cycle. Then i_req_val=1111 -> next grant is requester 3, then 0.
4. Slot FULL with A1, i_net_en=0 for 5 cycles -> o_data=A1 and o_data_val=1 stable, o_req_en=0000. i_net_en=1 -> A1 drains and requester 2 is accepted in the same cycle.
5. reset_n low for 1 cycle while FULL with A3 -> o_data_val=0 next cycle, pointer=0, A3 never delivered.
6. With ENOC_ARB_STATS_EN, CNT_WIDTH=4, single requester 1 for 20 accepts plus 3 stall cycles -> o_grant_cnt[1]=15 (saturated), others 0, o_stall_cnt=3.
